// File: rtl/vit_frontend_pkg.sv
// Shared ViT front-end definitions: patchifier state encodings, pixel type,
// default image geometry and the streamer FSM encoding.
package vit_frontend_pkg;

    localparam logic [2:0] PS_IDLE           = 3'b000;
    localparam logic [2:0] PS_PREPROCESSING  = 3'b001;
    localparam logic [2:0] PS_PROCESSING     = 3'b010;
    localparam logic [2:0] PS_POSTPROCESSING = 3'b011;
    localparam logic [2:0] PS_DONE           = 3'b100;

    localparam int DEF_CHANNEL_SIZE = 8;
    localparam int DEF_NUM_CHANNELS = 3;
    localparam int DEF_PIXEL_WIDTH  = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
    localparam int DEF_IMG_WIDTH    = 16;
    localparam int DEF_IMG_HEIGHT   = 16;
    localparam int DEF_PATCH_SIZE   = 4;

    typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/patch_addr_gen.sv
// Patch-major read address generator: patch counter p and in-patch position q,
// decoded into buffer coordinates (x, y) with bit slicing only.
module patch_addr_gen #(
    parameter int  PATCH_SIZE        = 4,
    parameter int  PATCHES_IN_ROW    = 4,
    parameter int  TOTAL_NUM_PATCHES = 16,
    parameter int  PATCH_VECTOR_SIZE = 16,
    localparam int PS_SH = $clog2(PATCH_SIZE),
    localparam int PC_W  = $clog2(PATCHES_IN_ROW),
    localparam int P_W   = $clog2(TOTAL_NUM_PATCHES),
    localparam int Q_W   = $clog2(PATCH_VECTOR_SIZE),
    localparam int PR_W  = P_W - PC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    input  logic                  clear,
    output logic [PC_W+PS_SH-1:0] x,
    output logic [PR_W+PS_SH-1:0] y,
    output logic [P_W-1:0]        p,
    output logic [Q_W-1:0]        q,
    output logic                  last_patch,
    output logic                  last_img
);

    logic [P_W-1:0] p_q, p_d;
    logic [Q_W-1:0] q_q, q_d;

    // Geometry is all powers of two, so "== N-1" is an all-ones test and the
    // q wrap to 0 is plain modular overflow.
    assign last_patch = &q_q;
    assign last_img   = last_patch && (&p_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        p_d = p_q;
        q_d = q_q;
        if (clear) begin
            p_d = '0;
            q_d = '0;
        end else if (advance) begin
            q_d = q_q + Q_W'(1);
            if (last_patch) begin
                p_d = p_q + P_W'(1);
            end
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
            q_q <= '0;
        end else begin
            p_q <= p_d;
            q_q <= q_d;
        end
    end

    // p = pr*PATCHES_IN_ROW + pc and q = r*PATCH_SIZE + c, so x = {pc, c}, y = {pr, r}.
    assign x = {p_q[PC_W-1:0], q_q[PS_SH-1:0]};
    assign y = {p_q[P_W-1:PC_W], q_q[Q_W-1:PS_SH]};
    assign p = p_q;
    assign q = q_q;

endmodule

// File: rtl/patch_streamer.sv
// Captures the patchifier image on DONE, releases it with a one-cycle pulse and
// streams it pixel by pixel in patch-major order over a valid/ready interface.
module patch_streamer
    import vit_frontend_pkg::*;
#(
    parameter int CHANNEL_SIZE      = DEF_CHANNEL_SIZE,
    parameter int NUM_CHANNELS      = DEF_NUM_CHANNELS,
    parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int IMG_WIDTH         = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT        = DEF_IMG_HEIGHT,
    parameter int PATCH_SIZE        = DEF_PATCH_SIZE,
    parameter int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE,
    parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [2:0]                           patch_state,
    input  logic [PIXEL_WIDTH-1:0]               all_patches [IMG_WIDTH][IMG_HEIGHT],
    output logic                                 output_taken,
    output logic                                 tok_valid,
    input  logic                                 tok_ready,
    output logic [PIXEL_WIDTH-1:0]               tok_pixel,
    output logic [$clog2(TOTAL_NUM_PATCHES)-1:0] tok_patch_idx,
    output logic [$clog2(PATCH_VECTOR_SIZE)-1:0] tok_pos_idx,
    output logic                                 tok_last_patch,
    output logic                                 tok_last_img,
    output logic                                 busy
);

    localparam int X_W = $clog2(IMG_WIDTH);
    localparam int Y_W = $clog2(IMG_HEIGHT);

    stream_state_e          state_q, state_d;
    logic                   output_taken_q, output_taken_d;
    logic [PIXEL_WIDTH-1:0] buf_q [IMG_WIDTH][IMG_HEIGHT];

    logic           capture;
    logic           handshake;
    logic           cnt_clear;
    logic [X_W-1:0] rd_x;
    logic [Y_W-1:0] rd_y;
    logic           last_patch;
    logic           last_img;

    assign handshake = (state_q == ST_STREAM) && tok_ready;

    // The output_taken guard stops a second capture while the patchifier is
    // still sitting in DONE during the release cycle.
    always_comb begin
        state_d        = state_q;
        output_taken_d = 1'b0;
        capture        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (patch_state == PS_DONE && !output_taken_q) begin
                    capture        = 1'b1;
                    output_taken_d = 1'b1;
                    state_d        = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (handshake && last_img) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_clear = capture || (handshake && last_img);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            output_taken_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            output_taken_q <= output_taken_d;
        end
    end

    // NOTE: the image buffer is storage, not control state; it has no reset and is fully rewritten on capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= all_patches;
        end
    end

    patch_addr_gen #(
        .PATCH_SIZE        (PATCH_SIZE),
        .PATCHES_IN_ROW    (PATCHES_IN_ROW),
        .TOTAL_NUM_PATCHES (TOTAL_NUM_PATCHES),
        .PATCH_VECTOR_SIZE (PATCH_VECTOR_SIZE)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .advance    (handshake),
        .clear      (cnt_clear),
        .x          (rd_x),
        .y          (rd_y),
        .p          (tok_patch_idx),
        .q          (tok_pos_idx),
        .last_patch (last_patch),
        .last_img   (last_img)
    );

    assign output_taken   = output_taken_q;
    assign tok_valid      = (state_q == ST_STREAM);
    assign busy           = (state_q != ST_IDLE);
    assign tok_pixel      = buf_q[rd_x][rd_y];
    assign tok_last_patch = last_patch;
    assign tok_last_img   = last_img;

endmodule

// File: doc/patch_streamer.md
# patch_streamer

Downstream neighbour of the patchifier in the ViT front end. Once the patchifier reaches DONE, the block captures its full `all_patches` array in one cycle and pulses `output_taken` to release it. It then streams the captured image out one pixel per beat on a valid/ready token interface, in patch-major order, tagged with patch index, position index and last markers. The consumer is the patch-embedding (linear projection) stage.

## Interface
Parameters:
- `CHANNEL_SIZE`, 8, bits per channel.
- `NUM_CHANNELS`, 3, channels per pixel.
- `PIXEL_WIDTH`, `CHANNEL_SIZE*NUM_CHANNELS`, pixel width.
- `IMG_WIDTH`, 16, image columns (first array index, x).
- `IMG_HEIGHT`, 16, image rows (second array index, y).
- `PATCH_SIZE`, 4, patch edge in pixels; must be a power of two.
- `PATCHES_IN_ROW`, `IMG_WIDTH/PATCH_SIZE`, patches per row.
- `TOTAL_NUM_PATCHES`, `(IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE)`, patches per image.
- `PATCH_VECTOR_SIZE`, `PATCH_SIZE*PATCH_SIZE`, pixels per patch.

Ports (`name  direction  width  meaning`):
- `clk  in  1  single clock, rising edge`
- `reset  in  1  asynchronous, active-low reset`
- `patch_state  in  3  patchifier state; DONE = 3'b100`
- `all_patches  in  PIXEL_WIDTH x [IMG_WIDTH][IMG_HEIGHT]  patchifier output array`
- `output_taken  out  1  one-cycle release pulse to the patchifier`
- `tok_valid  out  1  token beat valid`
- `tok_ready  in  1  consumer ready`
- `tok_pixel  out  PIXEL_WIDTH  pixel data`
- `tok_patch_idx  out  $clog2(TOTAL_NUM_PATCHES)  patch number p`
- `tok_pos_idx  out  $clog2(PATCH_VECTOR_SIZE)  position q within the patch`
- `tok_last_patch  out  1  high on the final position of each patch`
- `tok_last_img  out  1  high on the final beat of the image`
- `busy  out  1  high while the state is not IDLE`

## Operation
- The FSM has two states, IDLE and STREAM.
- IDLE → STREAM requires all three of: `patch_state==DONE`, `output_taken==0` and reset deasserted. On that edge:
  - the buffer loads `all_patches`;
  - `output_taken` is set to 1;
  - both counters clear.
- `output_taken` is forced to 0 on the following edge, so it is exactly one cycle wide.
- STREAM:
  - `tok_valid` = 1.
  - A handshake (`tok_valid && tok_ready`) advances `q`.
  - When `q` wraps from `PATCH_VECTOR_SIZE-1` to 0, `p` increments.
- Address mapping, with `pr=p/PATCHES_IN_ROW`, `pc=p%PATCHES_IN_ROW`, `r=q/PATCH_SIZE`, `c=q%PATCH_SIZE`:
  - `tok_pixel = buf[pc*PATCH_SIZE+c][pr*PATCH_SIZE+r]`.
  - Implement with shifts and masks only; no dividers.
- Last markers:
  - `tok_last_patch = (q==PATCH_VECTOR_SIZE-1)`.
  - `tok_last_img = tok_last_patch && (p==TOTAL_NUM_PATCHES-1)`.
- A handshake on the `tok_last_img` beat moves the FSM to IDLE and clears `p` and `q`.
- Backpressure: while `tok_ready=0`, all `tok_*` outputs hold stable and the counters hold.
- `patch_state` is ignored in STREAM. A new DONE is accepted only after the FSM returns to IDLE.
- Reset values: state IDLE; `output_taken` 0; `tok_valid` 0; `p` and `q` 0; `tok_patch_idx` and `tok_pos_idx` 0; `busy` 0. The buffer is not reset.
- Reset asserted mid-stream aborts immediately. Outputs take their reset values, with no partial-frame flush.

## Timing
- Capture edge k: `output_taken`, `tok_valid` and `busy` are all high in cycle k+1.
- The first beat is `p=0`, `q=0`, `tok_pixel=buf[0][0]`, presented in cycle k+1.
- `tok_pixel` and the tags decode combinationally from registered counters and the buffer. There is no added data latency.
- With `tok_ready` held at 1, one beat is accepted per cycle, for `IMG_WIDTH*IMG_HEIGHT` cycles in total (256 at defaults).
- `tok_valid` is 0 in the cycle after the last-beat handshake.
- The earliest next capture is the edge following return to IDLE.
- The patchifier leaves DONE on the edge that samples `output_taken=1`. The `output_taken==0` guard on the IDLE transition therefore blocks any double capture.

## Structure
- Shared package `vit_frontend_pkg` holds:
  - the patchifier state encodings (IDLE, PREPROCESSING, PROCESSING, POSTPROCESSING, DONE as 3-bit constants);
  - a `pixel_t` typedef;
  - the default geometry constants.
- One sub-module, `patch_addr_gen`:
  - contains the `p`/`q` counters with advance/clear inputs;
  - produces `x`, `y`, `p`, `q`, `last_patch` and `last_img`.
- The top level holds the FSM, the buffer, the read mux and the handshake.

## Test plan
- **Ordering:** load `all_patches[x][y]={8'h00,x[7:0],y[7:0]}`, pulse DONE, hold ready=1.
  - Beat 0 is `24'h000000`.
  - Beat 1 (`p0 q1`) is `24'h000100`.
  - Beat 86 (`p5 q6`) is `24'h000605`.
  - `tok_last_img` is high only on beat 255.
- **Release:** DONE held until `output_taken` is seen → `output_taken` is high exactly 1 cycle, and exactly 1 capture occurs.
- **Backpressure:** drop `tok_ready` for 3 cycles at beat 15.
  - `tok_pixel=24'h000303`, `tok_pos_idx=15` and `tok_last_patch=1` hold for the 3 cycles.
  - The next beat is `p1 q0` = `24'h000400`.
- **Busy ignore:** raise DONE again mid-stream → no recapture, and 256 beats still complete. Re-raising DONE after IDLE starts a second frame at `p0 q0`.
- **Mid-stream reset:** assert reset at beat 100.
  - `tok_valid` goes to 0 asynchronously.
  - After release, the state is IDLE with `p=q=0`, and a new DONE restarts the stream at beat 0.
- **Parameters:** `IMG_WIDTH=IMG_HEIGHT=8`, `PATCH_SIZE=2` → 64 beats in total. Beat 4 (`p1 q0`) is pixel `[2][0]`.
